// File: rtl/prf_pkg.sv
// Shared types and constants for the physical register file and its busy scoreboard.
package prf_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_PHYS_REGS  = 64;

  function automatic int logPhys(input int numRegs);
    return $clog2(numRegs);
  endfunction

  localparam int LOG_PHYS = logPhys(DEFAULT_PHYS_REGS);

  typedef logic [LOG_PHYS-1:0] preg_t;

endpackage

// File: rtl/prf_busy_scoreboard.sv
// Busy/ready scoreboard: flush beats alloc, alloc beats writeback; preg 0 optionally never busy.
module prf_busy_scoreboard
  import prf_pkg::*;
#(
  parameter int NUM_PHYS_REGS = DEFAULT_PHYS_REGS,
  parameter int NUM_WR        = 2,
  parameter int NUM_ALLOC     = 2,
  parameter int ZERO_REG      = 1,
  parameter int LOG           = logPhys(NUM_PHYS_REGS)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_WR-1:0]          wrEn,
  input  logic [NUM_WR*LOG-1:0]      wrAddr,
  input  logic [NUM_ALLOC-1:0]       allocEn,
  input  logic [NUM_ALLOC*LOG-1:0]   allocAddr,
  input  logic                       flush,
  output logic [NUM_PHYS_REGS-1:0]   busy
);

  logic [NUM_PHYS_REGS-1:0] busyNext;

  always_comb begin
    busyNext = busy;
    if (flush) begin
      busyNext = '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (wrEn[p]) busyNext[wrAddr[p*LOG +: LOG]] = 1'b0;
      // Applied after writebacks so a new producer keeps the register busy.
      for (int a = 0; a < NUM_ALLOC; a++)
        if (allocEn[a]) busyNext[allocAddr[a*LOG +: LOG]] = 1'b1;
    end
    if (ZERO_REG != 0) busyNext[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) busy <= '0;
    else        busy <= busyNext;
  end

endmodule

// File: rtl/phys_reg_file_mp.sv
// Multi-ported physical register file: data array, write arbitration, read bypass,
// sticky write-conflict flag, and an embedded busy scoreboard.
module phys_reg_file_mp
  import prf_pkg::*;
#(
  parameter int NUM_PHYS_REGS = DEFAULT_PHYS_REGS,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int NUM_RD        = 3,
  parameter int NUM_WR        = 2,
  parameter int NUM_ALLOC     = 2,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1,
  parameter int LOG           = logPhys(NUM_PHYS_REGS)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_RD*LOG-1:0]        rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]            rd_ready_o,
  input  logic [NUM_WR-1:0]            wr_en_i,
  input  logic [NUM_WR*LOG-1:0]        wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
  input  logic [NUM_ALLOC-1:0]         alloc_en_i,
  input  logic [NUM_ALLOC*LOG-1:0]     alloc_addr_i,
  input  logic                         flush_i,
  output logic [NUM_PHYS_REGS-1:0]     busy_o,
  output logic                         wr_conflict_o
);

  logic [DATA_WIDTH-1:0] regs [NUM_PHYS_REGS];
  logic [LOG-1:0]        wrAddr [NUM_WR];
  logic [DATA_WIDTH-1:0] wrData [NUM_WR];
  logic [NUM_WR-1:0]     wrValid;
  logic                  conflictNow;

  // Writes to a hardwired zero register are dropped before arbitration.
  for (genvar p = 0; p < NUM_WR; p++) begin : gWrPort
    assign wrAddr[p]  = wr_addr_i[p*LOG +: LOG];
    assign wrData[p]  = wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
    assign wrValid[p] = wr_en_i[p] && !((ZERO_REG != 0) && (wrAddr[p] == '0));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int r = 0; r < NUM_PHYS_REGS; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (wrValid[p]) regs[wrAddr[p]] <= wrData[p];
    end
  end

  always_comb begin
    conflictNow = 1'b0;
    for (int p = 0; p < NUM_WR; p++)
      for (int q = p + 1; q < NUM_WR; q++)
        if (wrValid[p] && wrValid[q] && (wrAddr[p] == wrAddr[q])) conflictNow = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)           wr_conflict_o <= 1'b0;
    else if (conflictNow) wr_conflict_o <= 1'b1;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRdPort
    logic [LOG-1:0]        rdAddr;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  bypassHit;

    assign rdAddr = rd_addr_i[i*LOG +: LOG];

    always_comb begin
      rdData    = regs[rdAddr];
      bypassHit = 1'b0;
      for (int p = 0; p < NUM_WR; p++)
        if ((BYPASS != 0) && wrValid[p] && (wrAddr[p] == rdAddr)) begin
          rdData    = wrData[p];
          bypassHit = 1'b1;
        end
      if ((ZERO_REG != 0) && (rdAddr == '0)) rdData = '0;
    end

    assign rd_data_o[i*DATA_WIDTH +: DATA_WIDTH] = rdData;
    assign rd_ready_o[i] = !busy_o[rdAddr] || bypassHit;
  end

  prf_busy_scoreboard #(
    .NUM_PHYS_REGS (NUM_PHYS_REGS),
    .NUM_WR        (NUM_WR),
    .NUM_ALLOC     (NUM_ALLOC),
    .ZERO_REG      (ZERO_REG),
    .LOG           (LOG)
  ) uScoreboard (
    .CLK       (CLK),
    .RESET     (RESET),
    .wrEn      (wr_en_i),
    .wrAddr    (wr_addr_i),
    .allocEn   (alloc_en_i),
    .allocAddr (alloc_addr_i),
    .flush     (flush_i),
    .busy      (busy_o)
  );

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Bench for phys_reg_file_mp: directed vector table, a no-bypass single-write instance,
// reset checks, and randomized traffic against an array-based reference model.
module tb_phys_reg_file_mp;

  localparam int NP = 64, DW = 32, NRD = 3, NWR = 2, NAL = 2, LG = 6;

  logic CLK = 1'b0;
  logic RESET;
  logic [NRD*LG-1:0] rdAddr;
  logic [NRD*DW-1:0] rdData;
  logic [NRD-1:0]    rdReady;
  logic [NWR-1:0]    wrEn;
  logic [NWR*LG-1:0] wrAddr;
  logic [NWR*DW-1:0] wrData;
  logic [NAL-1:0]    allocEn;
  logic [NAL*LG-1:0] allocAddr;
  logic              flush;
  logic [NP-1:0]     busy;
  logic              conflict;

  logic [LG-1:0] bRdAddr;
  logic [DW-1:0] bRdData;
  logic          bRdReady;
  logic          bWrEn;
  logic [LG-1:0] bWrAddr;
  logic [DW-1:0] bWrData;
  logic          bAllocEn;
  logic [LG-1:0] bAllocAddr;
  logic          bFlush;
  logic [NP-1:0] bBusy;
  logic          bConflict;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  phys_reg_file_mp #(
    .NUM_PHYS_REGS(NP), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_WR(NWR),
    .NUM_ALLOC(NAL), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .rd_addr_i(rdAddr), .rd_data_o(rdData), .rd_ready_o(rdReady),
    .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_data_i(wrData),
    .alloc_en_i(allocEn), .alloc_addr_i(allocAddr), .flush_i(flush),
    .busy_o(busy), .wr_conflict_o(conflict)
  );

  phys_reg_file_mp #(
    .NUM_PHYS_REGS(NP), .DATA_WIDTH(DW), .NUM_RD(1), .NUM_WR(1),
    .NUM_ALLOC(1), .ZERO_REG(1), .BYPASS(0)
  ) dutNb (
    .CLK(CLK), .RESET(RESET),
    .rd_addr_i(bRdAddr), .rd_data_o(bRdData), .rd_ready_o(bRdReady),
    .wr_en_i(bWrEn), .wr_addr_i(bWrAddr), .wr_data_i(bWrData),
    .alloc_en_i(bAllocEn), .alloc_addr_i(bAllocAddr), .flush_i(bFlush),
    .busy_o(bBusy), .wr_conflict_o(bConflict)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [5:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  ae;
    logic [5:0]  aa0, aa1;
    logic        fl;
    logic [5:0]  ra;
    logic [31:0] expData;
    logic        expReady, expBusy, expConf, chkZero;
  } vec_t;

  vec_t vecs[16];

  // Reference model state
  logic [DW-1:0] mReg [NP];
  logic [NP-1:0] mBusy;
  logic          mConf;

  task automatic idleAll();
    wrEn = '0; wrAddr = '0; wrData = '0;
    allocEn = '0; allocAddr = '0; flush = 1'b0; rdAddr = '0;
    bWrEn = 1'b0; bWrAddr = '0; bWrData = '0;
    bAllocEn = 1'b0; bAllocAddr = '0; bFlush = 1'b0; bRdAddr = '0;
  endtask

  task automatic modelReset();
    for (int r = 0; r < NP; r++) mReg[r] = '0;
    mBusy = '0;
    mConf = 1'b0;
  endtask

  initial begin
    //        we    wa0 wa1 wd0        wd1        ae    aa0 aa1 fl  ra  expData    rdy bsy cnf z
    vecs[0]  = '{2'b00, 0,  0, 32'h0,     32'h0,     2'b01, 12, 0, 0, 12, 32'h0,     1, 0, 0, 0};
    vecs[1]  = '{2'b00, 0,  0, 32'h0,     32'h0,     2'b00, 0,  0, 0, 12, 32'h0,     0, 1, 0, 0};
    vecs[2]  = '{2'b00, 0,  0, 32'h0,     32'h0,     2'b00, 0,  0, 0, 12, 32'h0,     0, 1, 0, 0};
    vecs[3]  = '{2'b01, 12, 0, 32'h1234,  32'h0,     2'b00, 0,  0, 0, 12, 32'h1234,  1, 1, 0, 0};
    vecs[4]  = '{2'b00, 0,  0, 32'h0,     32'h0,     2'b00, 0,  0, 0, 12, 32'h1234,  1, 0, 0, 0};
    vecs[5]  = '{2'b10, 0, 20, 32'h0,     32'hABCD,  2'b10, 0, 20, 0, 20, 32'hABCD,  1, 0, 0, 0};
    vecs[6]  = '{2'b00, 0,  0, 32'h0,     32'h0,     2'b00, 0,  0, 0, 20, 32'hABCD,  0, 1, 0, 0};
    vecs[7]  = '{2'b00, 0,  0, 32'h0,     32'h0,     2'b11, 3,  9, 0, 3,  32'h0,     1, 0, 0, 0};
    vecs[8]  = '{2'b00, 0,  0, 32'h0,     32'h0,     2'b01, 30, 0, 1, 9,  32'h0,     0, 1, 0, 0};
    vecs[9]  = '{2'b00, 0,  0, 32'h0,     32'h0,     2'b00, 0,  0, 0, 30, 32'h0,     1, 0, 0, 1};
    vecs[10] = '{2'b11, 0,  0, 32'hFFFF,  32'hFFFF,  2'b01, 0,  0, 0, 0,  32'h0,     1, 0, 0, 0};
    vecs[11] = '{2'b00, 0,  0, 32'h0,     32'h0,     2'b00, 0,  0, 0, 0,  32'h0,     1, 0, 0, 1};
    vecs[12] = '{2'b11, 7,  7, 32'h1,     32'h2,     2'b00, 0,  0, 0, 7,  32'h2,     1, 0, 0, 0};
    vecs[13] = '{2'b00, 0,  0, 32'h0,     32'h0,     2'b00, 0,  0, 0, 7,  32'h2,     1, 0, 1, 0};
    vecs[14] = '{2'b01, 8,  0, 32'h5,     32'h0,     2'b00, 0,  0, 0, 8,  32'h5,     1, 0, 1, 0};
    vecs[15] = '{2'b00, 0,  0, 32'h0,     32'h0,     2'b00, 0,  0, 0, 7,  32'h2,     1, 0, 1, 0};

    idleAll();
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;

    check("reset_busy", 64'(busy), 64'h0);
    check("reset_conflict", 64'(conflict), 64'h0);

    // Directed table on the bypassing, dual-write instance
    for (int v = 0; v < 16; v++) begin
      @(negedge CLK);
      wrEn = vecs[v].we;
      wrAddr = {vecs[v].wa1, vecs[v].wa0};
      wrData = {vecs[v].wd1, vecs[v].wd0};
      allocEn = vecs[v].ae;
      allocAddr = {vecs[v].aa1, vecs[v].aa0};
      flush = vecs[v].fl;
      rdAddr = {6'd0, 6'd0, vecs[v].ra};
      #1;
      check($sformatf("vec%0d_data", v), 64'(rdData[DW-1:0]), 64'(vecs[v].expData));
      check($sformatf("vec%0d_ready", v), 64'(rdReady[0]), 64'(vecs[v].expReady));
      check($sformatf("vec%0d_busybit", v), 64'(busy[vecs[v].ra]), 64'(vecs[v].expBusy));
      check($sformatf("vec%0d_conflict", v), 64'(conflict), 64'(vecs[v].expConf));
      if (vecs[v].chkZero) check($sformatf("vec%0d_busy_all", v), 64'(busy), 64'h0);
    end
    @(negedge CLK);
    idleAll();

    // No-bypass, single-write instance
    bAllocEn = 1'b1; bAllocAddr = 6'd12; bRdAddr = 6'd12;
    #1;
    check("nb_alloc_ready_same_cycle", 64'(bRdReady), 64'h1);
    @(negedge CLK);
    bAllocEn = 1'b0; bWrEn = 1'b1; bWrAddr = 6'd12; bWrData = 32'h1234;
    #1;
    check("nb_write_no_bypass_data", 64'(bRdData), 64'h0);
    check("nb_write_no_bypass_ready", 64'(bRdReady), 64'h0);
    check("nb_busy_12", 64'(bBusy[12]), 64'h1);
    @(negedge CLK);
    bWrEn = 1'b0;
    #1;
    check("nb_data_next_cycle", 64'(bRdData), 64'h1234);
    check("nb_ready_next_cycle", 64'(bRdReady), 64'h1);
    check("nb_busy_cleared", 64'(bBusy[12]), 64'h0);
    @(negedge CLK);
    bWrEn = 1'b1; bWrAddr = 6'd0; bWrData = 32'hFFFF;
    bAllocEn = 1'b1; bAllocAddr = 6'd0; bRdAddr = 6'd0;
    @(negedge CLK);
    bWrEn = 1'b0; bAllocEn = 1'b0;
    #1;
    check("nb_zero_data", 64'(bRdData), 64'h0);
    check("nb_zero_ready", 64'(bRdReady), 64'h1);
    check("nb_zero_busy", 64'(bBusy), 64'h0);
    check("nb_zero_conflict", 64'(bConflict), 64'h0);

    // Mid-cycle reset: preload 5, then reset with in-flight traffic
    @(negedge CLK);
    wrEn = 2'b01; wrAddr = {6'd0, 6'd5}; wrData = {32'h0, 32'hDEAD};
    allocEn = 2'b01; allocAddr = {6'd0, 6'd5};
    rdAddr = {6'd0, 6'd0, 6'd5};
    @(posedge CLK);
    #2;
    wrEn = '0;
    check("preload_busy5", 64'(busy[5]), 64'h1);
    check("preload_data5", 64'(rdData[DW-1:0]), 64'hDEAD);
    RESET = 1'b0;
    #1;
    check("rst_data5", 64'(rdData[DW-1:0]), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_conflict", 64'(conflict), 64'h0);
    wrEn = 2'b01; wrData = {32'h0, 32'hBEEF};
    @(posedge CLK);
    @(negedge CLK);
    idleAll();
    rdAddr = {6'd0, 6'd0, 6'd5};
    RESET = 1'b1;
    #1;
    check("post_rst_data5", 64'(rdData[DW-1:0]), 64'h0);
    check("post_rst_busy5", 64'(busy[5]), 64'h0);
    modelReset();

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge CLK);
      for (int p = 0; p < NWR; p++) begin
        wrEn[p] = ($urandom_range(0, 2) != 0);
        wrAddr[p*LG +: LG] = 6'($urandom_range(0, 15));
        wrData[p*DW +: DW] = $urandom;
      end
      for (int a = 0; a < NAL; a++) begin
        allocEn[a] = ($urandom_range(0, 2) == 0);
        allocAddr[a*LG +: LG] = 6'($urandom_range(0, 15));
      end
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NRD; i++) rdAddr[i*LG +: LG] = 6'($urandom_range(0, 15));
      #1;
      for (int i = 0; i < NRD; i++) begin
        int ra;
        logic [DW-1:0] expD;
        logic hit;
        ra = int'(rdAddr[i*LG +: LG]);
        hit = 1'b0;
        expD = mReg[ra];
        for (int p = 0; p < NWR; p++)
          if (wrEn[p] && int'(wrAddr[p*LG +: LG]) == ra && ra != 0) begin
            hit = 1'b1;
            expD = wrData[p*DW +: DW];
          end
        if (ra == 0) expD = '0;
        check($sformatf("rnd%0d_rd%0d_data", cyc, i), 64'(rdData[i*DW +: DW]), 64'(expD));
        check($sformatf("rnd%0d_rd%0d_ready", cyc, i), 64'(rdReady[i]),
              64'((ra == 0) || !mBusy[ra] || hit));
      end
      check($sformatf("rnd%0d_busy", cyc), 64'(busy), 64'(mBusy));
      check($sformatf("rnd%0d_conflict", cyc), 64'(conflict), 64'(mConf));

      begin
        logic [NP-1:0] nb;
        nb = mBusy;
        for (int r = 1; r < NP; r++) begin
          logic al, wb;
          al = 1'b0; wb = 1'b0;
          for (int a = 0; a < NAL; a++) if (allocEn[a] && int'(allocAddr[a*LG +: LG]) == r) al = 1'b1;
          for (int p = 0; p < NWR; p++) if (wrEn[p] && int'(wrAddr[p*LG +: LG]) == r) wb = 1'b1;
          nb[r] = flush ? 1'b0 : (al ? 1'b1 : (wb ? 1'b0 : mBusy[r]));
        end
        nb[0] = 1'b0;
        if (wrEn[0] && wrEn[1] && wrAddr[0 +: LG] == wrAddr[LG +: LG] && wrAddr[0 +: LG] != 0)
          mConf = 1'b1;
        for (int p = 0; p < NWR; p++)
          if (wrEn[p] && wrAddr[p*LG +: LG] != 0) mReg[int'(wrAddr[p*LG +: LG])] = wrData[p*DW +: DW];
        mBusy = nb;
      end
    end

    @(negedge CLK);
    idleAll();
    #1;
    check("final_busy", 64'(busy), 64'(mBusy));
    check("final_conflict", 64'(conflict), 64'(mConf));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
